// File: rtl/uart_host.sv
// Host-side serial link partner: 32-bit words in and out as four 8N1 frames, MSB byte first.
// It runs on the SoC clock, so datai is sampled directly with no synchroniser.
module uart_host #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        datai,
    output logic        datao,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_busy,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_frame_err,
    output logic        rx_trunc
);

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_STOP, R_RECOVER} rx_state_t;

    tx_state_t   t_state, t_nxt;
    logic [7:0]  t_cnt, t_cnt_nxt;
    logic [2:0]  t_bit, t_bit_nxt;
    logic [1:0]  t_byte, t_byte_nxt;
    logic [31:0] t_sh, t_sh_nxt;
    logic [7:0]  t_cur;
    logic        t_bit_end;
    logic        datao_nxt;

    rx_state_t   r_state, r_nxt;
    logic [7:0]  r_cnt, r_cnt_nxt;
    logic [2:0]  r_bit, r_bit_nxt;
    logic [1:0]  r_byte, r_byte_nxt;
    logic [7:0]  r_sh, r_sh_nxt;
    logic [31:0] r_word, r_word_nxt;
    logic [31:0] rx_data_nxt;
    logic        r_bit_end;
    logic        rx_valid_nxt, rx_frame_err_nxt, rx_trunc_nxt;

    assign t_bit_end = (t_cnt == CNT_LAST);
    assign r_bit_end = (r_cnt == CNT_LAST);

    always_comb begin
        t_nxt      = t_state;
        t_cnt_nxt  = t_cnt;
        t_bit_nxt  = t_bit;
        t_byte_nxt = t_byte;
        t_sh_nxt   = t_sh;
        t_cur      = 8'h00;
        datao_nxt  = 1'b1;
        if (t_state != T_IDLE)
            t_cnt_nxt = t_bit_end ? 8'd0 : t_cnt + 8'd1;
        case (t_state)
            T_IDLE: begin
                if (tx_valid && tx_ready) begin
                    t_sh_nxt   = tx_data;
                    t_byte_nxt = 2'd0;
                    t_bit_nxt  = 3'd0;
                    t_cnt_nxt  = 8'd0;
                    t_nxt      = T_START;
                end
            end
            T_START: begin
                if (t_bit_end) begin
                    t_bit_nxt = 3'd0;
                    t_nxt     = T_DATA;
                end
            end
            T_DATA: begin
                if (t_bit_end) begin
                    t_bit_nxt = t_bit + 3'd1;
                    if (t_bit == 3'd7)
                        t_nxt = T_STOP;
                end
            end
            T_STOP: begin
                if (t_bit_end) begin
                    if (t_byte == 2'd3) begin
                        t_nxt = T_IDLE;
                    end else begin
                        t_byte_nxt = t_byte + 2'd1;
                        t_sh_nxt   = {t_sh[23:0], 8'h00};
                        t_nxt      = T_START;
                    end
                end
            end
            default: t_nxt = T_IDLE;
        endcase
        // datao is registered, so it is computed from the state being entered
        t_cur = t_sh_nxt[31:24];
        case (t_nxt)
            T_START: datao_nxt = 1'b0;
            T_DATA:  datao_nxt = t_cur[t_bit_nxt];
            default: datao_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            t_state  <= T_IDLE;
            t_cnt    <= 8'd0;
            t_bit    <= 3'd0;
            t_byte   <= 2'd0;
            datao    <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            t_state  <= t_nxt;
            t_cnt    <= t_cnt_nxt;
            t_bit    <= t_bit_nxt;
            t_byte   <= t_byte_nxt;
            datao    <= datao_nxt;
            tx_ready <= (t_nxt == T_IDLE);
            tx_busy  <= (t_nxt != T_IDLE);
        end
    end

    always_comb begin
        r_nxt            = r_state;
        r_cnt_nxt        = r_cnt;
        r_bit_nxt        = r_bit;
        r_byte_nxt       = r_byte;
        r_sh_nxt         = r_sh;
        r_word_nxt       = r_word;
        rx_data_nxt      = rx_data;
        rx_valid_nxt     = 1'b0;
        rx_frame_err_nxt = 1'b0;
        rx_trunc_nxt     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (!datai) begin
                    r_cnt_nxt = 8'd0;
                    r_bit_nxt = 3'd0;
                    r_nxt     = R_DATA;
                end else if (r_byte != 2'd0) begin
                    // a partial word followed by a full idle bit time is abandoned
                    if (r_bit_end) begin
                        rx_trunc_nxt = 1'b1;
                        r_byte_nxt   = 2'd0;
                        r_cnt_nxt    = 8'd0;
                    end else begin
                        r_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            R_DATA: begin
                if (r_bit_end) begin
                    r_cnt_nxt = 8'd0;
                    r_sh_nxt  = {datai, r_sh[7:1]};
                    r_bit_nxt = r_bit + 3'd1;
                    if (r_bit == 3'd7)
                        r_nxt = R_STOP;
                end else begin
                    r_cnt_nxt = r_cnt + 8'd1;
                end
            end
            R_STOP: begin
                if (r_bit_end) begin
                    r_cnt_nxt = 8'd0;
                    if (datai) begin
                        r_word_nxt = {r_word[23:0], r_sh};
                        if (r_byte == 2'd3) begin
                            rx_data_nxt  = {r_word[23:0], r_sh};
                            rx_valid_nxt = 1'b1;
                            r_byte_nxt   = 2'd0;
                        end else begin
                            r_byte_nxt = r_byte + 2'd1;
                        end
                        r_nxt = R_IDLE;
                    end else begin
                        rx_frame_err_nxt = 1'b1;
                        r_byte_nxt       = 2'd0;
                        r_nxt            = R_RECOVER;
                    end
                end else begin
                    r_cnt_nxt = r_cnt + 8'd1;
                end
            end
            R_RECOVER: begin
                if (!datai) begin
                    r_cnt_nxt = 8'd0;
                end else if (r_bit_end) begin
                    r_cnt_nxt = 8'd0;
                    r_nxt     = R_IDLE;
                end else begin
                    r_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= R_IDLE;
            r_cnt        <= 8'd0;
            r_bit        <= 3'd0;
            r_byte       <= 2'd0;
            rx_data      <= 32'd0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_trunc     <= 1'b0;
        end else begin
            r_state      <= r_nxt;
            r_cnt        <= r_cnt_nxt;
            r_bit        <= r_bit_nxt;
            r_byte       <= r_byte_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
            rx_frame_err <= rx_frame_err_nxt;
            rx_trunc     <= rx_trunc_nxt;
        end
    end

    // shift registers carry payload only; byte/bit counters decide when they are meaningful
    always_ff @(posedge clk) begin
        t_sh   <= t_sh_nxt;
        r_sh   <= r_sh_nxt;
        r_word <= r_word_nxt;
    end

endmodule

// File: tb/tb_uart_host.sv
// Randomised bench for uart_host: frame-level line model for TX, word queue model for RX.
`timescale 1ns/1ps
module tb_uart_host;

    localparam int CPB = 1;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        datai;
    logic        datao;
    logic [31:0] tx_data = 32'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_busy;
    logic [31:0] rx_data;
    logic        rx_valid, rx_frame_err, rx_trunc;
    logic        drv_bit = 1'b1;
    logic        loop = 1'b0;

    assign datai = loop ? datao : drv_bit;

    uart_host #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .nrst(nrst), .datai(datai), .datao(datao),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_trunc(rx_trunc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Receive-side observer: every word pulse and error pulse seen out of reset
    logic [31:0] rxq[$];
    int n_ferr = 0;
    int n_trunc = 0;
    always @(negedge clk) begin
        if (nrst) begin
            if (rx_valid) rxq.push_back(rx_data);
            if (rx_frame_err) n_ferr++;
            if (rx_trunc) n_trunc++;
        end
    end

    // Line image of one word: per byte (MSB byte first) start 0, 8 bits LSB first, stop 1
    function automatic logic [39:0] line_bits(input logic [31:0] w);
        logic [39:0] v;
        logic [7:0]  by;
        v = '0;
        for (int b = 0; b < 4; b++) begin
            by = w[31 - 8*b -: 8];
            v[10*b] = 1'b0;
            for (int k = 0; k < 8; k++) v[10*b + 1 + k] = by[k];
            v[10*b + 9] = 1'b1;
        end
        return v;
    endfunction

    task automatic tx_send(input logic [31:0] w);
        int t;
        t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_wait", 32'(tx_ready), 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = $urandom;
    endtask

    task automatic tx_check(input logic [31:0] w, output logic [39:0] seen);
        logic [39:0] exp;
        exp  = line_bits(w);
        seen = '0;
        tx_send(w);
        for (int i = 0; i < 40; i++) begin
            seen[i] = datao;
            check($sformatf("datao_bit%0d_%08h", i, w), 32'(datao), 32'(exp[i]));
            check($sformatf("tx_busy_bit%0d", i), 32'({tx_ready, tx_busy}), 32'd1);
            tx_valid = (i == 20);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("tx_ready_after_word", 32'({tx_ready, tx_busy}), 32'd2);
    endtask

    task automatic drive_frame(input logic [7:0] by, input logic stopb);
        drv_bit = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            drv_bit = by[k];
            repeat (CPB) @(negedge clk);
        end
        drv_bit = stopb;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drive_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) drive_frame(w[31 - 8*b -: 8], 1'b1);
    endtask

    task automatic wait_rx(input int n, input string tag);
        int t;
        t = 0;
        while (rxq.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check(tag, 32'(rxq.size()), 32'(n));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] seen;
        logic [31:0] prev, w;
        logic [31:0] expq[$];
        int base, fe0, tr0, gap;

        repeat (3) @(negedge clk);
        check("rst_datao", 32'(datao), 32'd1);
        check("rst_tx_ready_busy", 32'({tx_ready, tx_busy}), 32'd2);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_pulses", 32'({rx_valid, rx_frame_err, rx_trunc}), 32'd0);
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle_c%0d", i),
                  32'({datao, tx_ready, tx_busy, rx_valid, rx_frame_err, rx_trunc}), 32'h30);
        end

        // TX framing, fixed then random words
        tx_check(32'h12345678, seen);
        check("first_byte_line", 32'(seen[9:0]), 32'h224);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            tx_check($urandom, seen);
        end

        // Loopback of two back-to-back words
        base = rxq.size(); fe0 = n_ferr; tr0 = n_trunc;
        loop = 1'b1;
        tx_send(32'hDEADBEEF);
        tx_send(32'h00000001);
        wait_rx(base + 2, "loop_count");
        if (rxq.size() >= base + 2) begin
            check("loop_word0", rxq[base], 32'hDEADBEEF);
            check("loop_word1", rxq[base + 1], 32'h00000001);
        end
        check("loop_no_ferr", 32'(n_ferr - fe0), 32'd0);
        check("loop_no_trunc", 32'(n_trunc - tr0), 32'd0);

        // Random loopback words
        base = rxq.size();
        expq.delete();
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            expq.push_back(w);
            tx_send(w);
        end
        wait_rx(base + 4, "loop_rand_count");
        for (int i = 0; i < 4; i++)
            if (rxq.size() > base + i) check($sformatf("loop_rand%0d", i), rxq[base + i], expq[i]);
        loop = 1'b0;
        drv_bit = 1'b1;
        repeat (3) @(negedge clk);

        // Bad stop bit, then a clean all-zero word
        base = rxq.size(); fe0 = n_ferr; tr0 = n_trunc; prev = rx_data;
        drive_frame(8'hA5, 1'b0);
        drv_bit = 1'b1;
        repeat (3) @(negedge clk);
        check("ferr_once", 32'(n_ferr - fe0), 32'd1);
        check("ferr_no_valid", 32'(rxq.size() - base), 32'd0);
        check("ferr_rx_data_kept", rx_data, prev);
        drive_word(32'h00000000);
        wait_rx(base + 1, "after_ferr_count");
        if (rxq.size() > base) check("after_ferr_word", rxq[base], 32'h00000000);
        check("after_ferr_no_more_ferr", 32'(n_ferr - fe0), 32'd1);
        check("after_ferr_no_trunc", 32'(n_trunc - tr0), 32'd0);

        // Truncated word: two good bytes then idle
        base = rxq.size(); tr0 = n_trunc; prev = rx_data;
        drive_frame(8'($urandom_range(1, 255)), 1'b1);
        drive_frame(8'($urandom_range(1, 255)), 1'b1);
        drv_bit = 1'b1;
        check("trunc_not_early", 32'(rx_trunc), 32'd0);
        @(negedge clk);
        check("trunc_pulse", 32'(rx_trunc), 32'd1);
        @(negedge clk);
        check("trunc_one_cycle", 32'(rx_trunc), 32'd0);
        repeat (5) @(negedge clk);
        check("trunc_count", 32'(n_trunc - tr0), 32'd1);
        check("trunc_rx_data_kept", rx_data, prev);
        check("trunc_no_valid", 32'(rxq.size() - base), 32'd0);
        w = $urandom;
        drive_word(w);
        wait_rx(base + 1, "after_trunc_count");
        if (rxq.size() > base) check("after_trunc_word", rxq[base], w);

        // Random direct-driven words with random idle gaps
        base = rxq.size(); fe0 = n_ferr; tr0 = n_trunc;
        expq.delete();
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            expq.push_back(w);
            drive_word(w);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        wait_rx(base + 4, "rx_rand_count");
        for (int i = 0; i < 4; i++)
            if (rxq.size() > base + i) check($sformatf("rx_rand%0d", i), rxq[base + i], expq[i]);
        check("rx_rand_no_err", 32'((n_ferr - fe0) + (n_trunc - tr0)), 32'd0);

        // Reset in the middle of the second TX byte
        tx_send($urandom);
        repeat (13) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("midrst_datao", 32'(datao), 32'd1);
        check("midrst_ready_busy", 32'({tx_ready, tx_busy}), 32'd2);
        check("midrst_rx_data", rx_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_hold_datao", 32'(datao), 32'd1);
        nrst = 1'b1;
        @(negedge clk);
        tx_check(32'h00FF00FF, seen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_host.md
Name: uart_host

Overview:
- Host-side link partner for the SoC serial port: drives the SoC's serial input and decodes the SoC's serial output.
- TX path: accepts 32-bit words on a valid/ready interface, for example image rows to be loaded into SoC RAM, and serialises them onto `datao`.
- RX path: deserialises `datai` into 32-bit words, for example encoded JPEG output or error codes, and presents them as one-cycle valid pulses.
- Used in the SoC bench and in the FPGA top as the PC-side bridge. It runs on the same clock as the SoC, so there is no synchroniser.

Parameters:
- CLKS_PER_BIT, 1: clock cycles per serial bit. Legal range 1..255. The SoC link uses 1.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- datai  in  1  serial input, connected to the SoC serial output; idle level 1
- datao  out  1  serial output, connected to the SoC serial input; idle level 1
- tx_data  in  32  word to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  TX can accept a word this cycle
- tx_busy  out  1  a TX word is in progress
- rx_data  out  32  last assembled word
- rx_valid  out  1  one-cycle pulse: rx_data has just been updated
- rx_frame_err  out  1  one-cycle pulse: stop bit was 0
- rx_trunc  out  1  one-cycle pulse: line went idle mid-word

Behaviour:
- Frame format, both directions: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- Word format, both directions: 4 bytes sent MSB byte first (bits [31:24], then [23:16], then [15:8], then [7:0]).
- Within a word, bytes are back-to-back: the next start bit immediately follows the previous stop bit.
- Reset values:
  - datao=1, tx_ready=1, tx_busy=0
  - rx_data=0, rx_valid=0, rx_frame_err=0, rx_trunc=0
  - all counters 0; both FSMs in their IDLE state
- Reset asserted mid-operation aborts any frame: datao returns to 1 immediately and any partial RX word is discarded.
- All outputs are registered.
- TX FSM, states T_IDLE, T_START, T_DATA, T_STOP:
  - T_IDLE: tx_ready=1. On tx_valid&&tx_ready, latch tx_data, set byte index=0, go to T_START.
  - T_START drives datao=0, T_DATA drives the current data bit, T_STOP drives datao=1. Each state/bit holds for CLKS_PER_BIT cycles.
  - At the end of T_STOP: if byte index<3, increment it and go to T_START; if byte index=3, go to T_IDLE.
  - One word therefore occupies 40*CLKS_PER_BIT cycles.
  - datao goes low on the first cycle after the accepting edge.
  - tx_ready=0 in every state except T_IDLE. Words are therefore separated by at least one idle cycle at datao=1.
  - tx_busy = !tx_ready.
  - tx_data is ignored while tx_ready=0.
- RX FSM, states R_IDLE, R_DATA, R_STOP, R_RECOVER:
  - Sampling is at bit boundaries. Define s = the cycle in which datai=0 is first seen in R_IDLE (start detect). Data bit k (k=0..7) is sampled at s+(k+1)*CLKS_PER_BIT; the stop bit is sampled at s+9*CLKS_PER_BIT.
  - Stop bit = 1: shift the byte into the word register at position 3-byte_index.
    - If byte_index was 3: on the next cycle rx_data=word and rx_valid=1 for one cycle; byte_index becomes 0.
    - Otherwise: increment byte_index.
    - Either way go to R_IDLE, which accepts a start bit immediately on the next sample.
  - Stop bit = 0: rx_frame_err pulses for one cycle, the partial word is discarded, byte_index becomes 0, go to R_RECOVER.
  - R_RECOVER: wait until datai=1 has been seen for CLKS_PER_BIT consecutive cycles, then go to R_IDLE.
  - Truncation: in R_IDLE with byte_index≠0, if datai=1 for CLKS_PER_BIT consecutive cycles, rx_trunc pulses for one cycle, byte_index becomes 0 and the partial word is discarded.
  - rx_data holds its value until the next complete word; it is never cleared by an error.
- TX and RX are fully independent and may run simultaneously.

Test Plan:
- Reset, then idle for 20 cycles -> datao=1, tx_ready=1, all pulse outputs 0 throughout.
- CLKS_PER_BIT=1; send tx_data=0x12345678 -> datao carries bytes 0x12, 0x34, 0x56, 0x78, each framed 0|LSB-first|1. First byte bits: 0,0,1,0,0,1,0,0,0,1. tx_ready is low for exactly 40 cycles, then high.
- Loop datao back to datai; send 0xDEADBEEF then 0x00000001 as two back-to-back accepted words -> exactly two rx_valid pulses, with rx_data=0xDEADBEEF and then 0x00000001. No error pulses.
- Drive datai with byte 0xA5 whose stop bit is forced to 0 -> rx_frame_err pulses once, rx_valid stays 0, and the next clean word 0x00000000 is received correctly.
- Drive datai with 2 good bytes, then hold datai at 1 -> rx_trunc pulses exactly CLKS_PER_BIT cycles after the stop bit ends; rx_data is unchanged.
- Assert nrst in the middle of the second TX byte -> datao=1 and tx_ready=1 during reset. After release, a new word 0x00FF00FF transmits correctly from its start bit.
